// File: rtl/fetch_decode_if.sv
// fetch_decode_if: instruction-memory req/ack bus plus micro-op valid/ready bus
interface fetch_decode_if;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       uop_valid;
  logic       uop_ready;
  logic [1:0] uop_kind;
  logic [5:0] uop_regsel;
  logic [2:0] uop_aluop;
  logic [7:0] uop_imm;
  modport master(
    output mem_req, mem_addr, uop_valid, uop_kind, uop_regsel, uop_aluop, uop_imm,
    input  mem_ack, mem_rdata, uop_ready
  );
  modport slave(
    input  mem_req, mem_addr, uop_valid, uop_kind, uop_regsel, uop_aluop, uop_imm,
    output mem_ack, mem_rdata, uop_ready
  );
endinterface

// File: rtl/fetch_decode.sv
// fetch_decode: fetches two-byte instructions, consumes NOP/JMP, issues ALU/LI micro-ops
module fetch_decode #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_if.master        bus,
  output logic [7:0]            pc,
  output logic [15:0]           issue_count
);
  typedef enum logic [1:0] {FETCH0, FETCH1, ISSUE} state_e;
  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d, b0_q, b0_d, imm_q, imm_d;
  logic [1:0]  kind_q, kind_d;
  logic [5:0]  regsel_q, regsel_d;
  logic [2:0]  aluop_q, aluop_d;
  logic [15:0] issue_count_q, issue_count_d;
  logic        issues;
  // ALU (01) and LI (10) are the only kinds that reach the downstream domain
  assign issues = ^b0_q[7:6];
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    b0_d          = b0_q;
    kind_d        = kind_q;
    regsel_d      = regsel_q;
    aluop_d       = aluop_q;
    imm_d         = imm_q;
    issue_count_d = issue_count_q;
    if (state_q == FETCH0 && bus.mem_ack) begin
      b0_d    = bus.mem_rdata;
      pc_d    = pc_q + 8'd1;
      state_d = FETCH1;
    end
    if (state_q == FETCH1 && bus.mem_ack) begin
      pc_d    = (b0_q[7:6] == 2'b11) ? bus.mem_rdata : pc_q + 8'd1;
      state_d = issues ? ISSUE : FETCH0;
      if (issues) begin
        kind_d   = b0_q[7:6];
        regsel_d = b0_q[5:0];
        aluop_d  = b0_q[6] ? bus.mem_rdata[2:0] : 3'd0;
        imm_d    = b0_q[7] ? bus.mem_rdata : 8'd0;
      end
    end
    if (state_q == ISSUE && bus.uop_ready) begin
      issue_count_d = issue_count_q + 16'd1;
      state_d       = FETCH0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH0;
      pc_q          <= RESET_PC;
      b0_q          <= 8'd0;
      kind_q        <= 2'd0;
      regsel_q      <= 6'd0;
      aluop_q       <= 3'd0;
      imm_q         <= 8'd0;
      issue_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      b0_q          <= b0_d;
      kind_q        <= kind_d;
      regsel_q      <= regsel_d;
      aluop_q       <= aluop_d;
      imm_q         <= imm_d;
      issue_count_q <= issue_count_d;
    end
  end
  assign bus.mem_req    = (state_q != ISSUE) && !reset;
  assign bus.mem_addr   = pc_q;
  assign bus.uop_valid  = state_q == ISSUE;
  assign bus.uop_kind   = kind_q;
  assign bus.uop_regsel = regsel_q;
  assign bus.uop_aluop  = aluop_q;
  assign bus.uop_imm    = imm_q;
  assign pc             = pc_q;
  assign issue_count    = issue_count_q;
endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front-end stage feeding the execution domain: fetches two-byte instructions from an 8-bit instruction memory over a req/ack handshake, decodes them, and issues one micro-op at a time (register select, ALU opcode, immediate) to the downstream domain over a valid/ready handshake. Jumps and NOPs are consumed internally and never issued. Sits directly upstream of the domain, driving its `regsel` and ALU controls.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  instruction fetch request.
- `mem_addr`  out  8  fetch address (= PC).
- `mem_ack`  in  1  fetch complete; `mem_rdata` valid this cycle.
- `mem_rdata`  in  8  fetched byte.
- `uop_valid`  out  1  micro-op presented.
- `uop_ready`  in  1  downstream accepts micro-op.
- `uop_kind`  out  2  01 = ALU, 10 = LI (load immediate).
- `uop_regsel`  out  6  destination/source register select.
- `uop_aluop`  out  3  ALU opcode (ALU kind only, else 0).
- `uop_imm`  out  8  immediate (LI kind only, else 0).
- `pc`  out  8  current program counter.
- `issue_count`  out  16  number of micro-ops accepted downstream, wraps.

## Operation
- Encoding: byte0 = {kind[1:0], regsel[5:0]}; byte1 = imm8. Kinds: 00 NOP, 01 ALU (aluop = byte1[2:0], byte1[7:3] ignored), 10 LI, 11 JMP (target = byte1).
- FSM states: FETCH0, FETCH1, ISSUE. Reset state FETCH0.
- `mem_req` = 1 in FETCH0/FETCH1 and not in reset; 0 in ISSUE. `mem_addr` = `pc` always.
- FETCH0: on `mem_ack`, latch byte0, `pc` <= `pc`+1, go FETCH1; else hold (req stays high, addr stable).
- FETCH1: on `mem_ack`, latch byte1, `pc` <= `pc`+1, then by kind: NOP -> FETCH0; JMP -> `pc` <= byte1 (overrides increment), FETCH0; ALU/LI -> load uop registers, go ISSUE.
- ISSUE: `uop_valid` = 1, all uop_* fields stable until `uop_ready`. On `uop_valid && uop_ready`: `issue_count` += 1, go FETCH0. No fetch in ISSUE.
- `pc` arithmetic modulo 256: 8'hFF + 1 = 8'h00; an instruction straddling FF/00 fetches byte1 from 8'h00.
- `mem_ack` outside FETCH0/FETCH1 is ignored.
- `issue_count` 16-bit, 16'hFFFF + 1 = 16'h0000.
- Reset mid-operation (any state, incl. held ISSUE or pending fetch) aborts: next cycle is FETCH0 with reset values; in-flight micro-op is dropped and not counted.

## Timing
- Reset values: `pc` = RESET_PC, `mem_req` = 0 (during reset), `mem_addr` = RESET_PC, `uop_valid` = 0, `uop_kind`/`uop_regsel`/`uop_aluop`/`uop_imm` = 0, `issue_count` = 0.
- `uop_*` and `pc` registered; `mem_req`, `uop_valid` decoded from state.
- Zero-wait memory (ack same cycle as req): ALU/LI = 3 cycles per instruction with `uop_ready` held high; NOP/JMP = 2 cycles.
- First `mem_req` in the first cycle after `reset` deasserts.
- Each memory wait cycle or `uop_ready` low cycle adds one cycle; no limit on either.

## Test plan
- Reset release, memory returns 8'h45, 8'h03 with immediate ack, `uop_ready`=1 -> addr 00 then 01, `uop_valid` on cycle 3 with kind 01, regsel 05, aluop 3, imm 0; `issue_count` = 1; `pc` = 02.
- LI 8'h8A,8'h7F with `uop_ready` low 4 cycles -> `uop_valid` held, fields stable (kind 10, regsel 0A, imm 7F), `mem_req` 0, count increments once on accept.
- JMP 8'hC0,8'h40 at 00 -> no `uop_valid`, next `mem_addr` = 40; NOP 8'h00,8'hxx -> no issue, `pc` advances by 2.
- `RESET_PC` = 8'hFF, ALU instruction at FF/00 -> byte0 from FF, byte1 from 00, `pc` = 01 after.
- `mem_ack` withheld 3 cycles in FETCH1 -> `mem_req` high, `mem_addr` stable; `reset` asserted while in ISSUE -> `uop_valid` 0 next cycle, `issue_count` unchanged at 0, fetch restarts at RESET_PC.
- 65536 issued micro-ops (or force-preloaded count 16'hFFFF) -> `issue_count` wraps to 0.
